// File: rtl/rare_node_activity_monitor.sv
// Observes one subcircuit net over a 2**WIN_W-cycle window. It counts ones and toggles,
// flags near-constant nodes as rare, and hands the result to a collector via valid/ready.
module rare_node_activity_monitor #(
  parameter int WIN_W    = 3,
  parameter int CNT_W    = 4,
  parameter int RARE_THR = 1,
  parameter int HIST_W   = 8
) (
  input  logic              I1470_clk,
  input  logic              I1477_rst,
  input  logic              start,
  input  logic              node_in,
  output logic              busy,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic [CNT_W-1:0]  tog_cnt,
  output logic              rare_flag,
  output logic [HIST_W-1:0] history
);

  typedef enum logic [1:0] {IDLE, SAMPLE, REPORT} state_e;

  localparam logic [CNT_W-1:0] N_C      = CNT_W'(2 ** WIN_W);
  localparam logic [CNT_W-1:0] THR_C    = CNT_W'(RARE_THR);
  localparam logic [CNT_W-1:0] HI_C     = N_C - THR_C;
  localparam logic [WIN_W-1:0] WIN_LAST = {WIN_W{1'b1}};

  state_e              state_q, state_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    ones_q, ones_d;
  logic [CNT_W-1:0]    tog_q, tog_d;
  logic                rare_q, rare_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic                prev_q, prev_d;
  logic [CNT_W-1:0]    ones_inc;

  assign ones_inc = ones_q + CNT_W'(node_in);

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      ones_q  <= '0;
      tog_q   <= '0;
      rare_q  <= 1'b0;
      hist_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ones_q  <= ones_d;
      tog_q   <= tog_d;
      rare_q  <= rare_d;
      hist_q  <= hist_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ones_d  = ones_q;
    tog_d   = tog_q;
    rare_d  = rare_q;
    hist_d  = hist_q;
    prev_d  = prev_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          win_d   = '0;
          ones_d  = '0;
          tog_d   = '0;
          rare_d  = 1'b0;
          hist_d  = '0;
          prev_d  = 1'b0;
        end
      end
      SAMPLE: begin
        hist_d = {hist_q[HIST_W-2:0], node_in};
        ones_d = ones_inc;
        prev_d = node_in;
        win_d  = win_q + WIN_W'(1);
        // The first sample has no predecessor, so it can never count as a toggle.
        if ((win_q != '0) && (node_in != prev_q)) tog_d = tog_q + CNT_W'(1);
        if (win_q == WIN_LAST) begin
          state_d = REPORT;
          rare_d  = (ones_inc <= THR_C) || (ones_inc >= HI_C);
        end
      end
      REPORT: begin
        if (rpt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign rpt_valid = (state_q == REPORT);
  assign ones_cnt  = ones_q;
  assign tog_cnt   = tog_q;
  assign rare_flag = rare_q;
  assign history   = hist_q;

endmodule

// File: tb/tb_rare_node_activity_monitor.sv
// Directed bench for rare_node_activity_monitor with N=8, RARE_THR=1, HIST_W=8.
module tb_rare_node_activity_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       node_in;
  logic       busy;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [3:0] ones_cnt;
  logic [3:0] tog_cnt;
  logic       rare_flag;
  logic [7:0] history;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] pat;   // bit7 = first sample s1, bit0 = last sample s8
    int         ones;
    int         tog;
    logic       rare;
    logic [7:0] hist;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  rare_node_activity_monitor #(
    .WIN_W(3), .CNT_W(4), .RARE_THR(1), .HIST_W(8)
  ) dut (
    .I1470_clk (clk),
    .I1477_rst (rst),
    .start     (start),
    .node_in   (node_in),
    .busy      (busy),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .ones_cnt  (ones_cnt),
    .tog_cnt   (tog_cnt),
    .rare_flag (rare_flag),
    .history   (history)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " valid"}, 32'(rpt_valid), 0);
    chk({tag, " ones"}, 32'(ones_cnt), 0);
    chk({tag, " tog"}, 32'(tog_cnt), 0);
    chk({tag, " rare"}, 32'(rare_flag), 0);
    chk({tag, " hist"}, 32'(history), 0);
  endtask

  task automatic chk_report(input string tag, input vec_t v);
    chk({tag, " ones"}, 32'(ones_cnt), 32'(v.ones));
    chk({tag, " tog"}, 32'(tog_cnt), 32'(v.tog));
    chk({tag, " rare"}, 32'(rare_flag), 32'(v.rare));
    chk({tag, " hist"}, 32'(history), 32'(v.hist));
  endtask

  // Start a window and feed the eight samples; leaves the DUT in REPORT.
  task automatic fill_window(input string tag, input vec_t v);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy after start"}, 32'(busy), 1);
    for (int i = 1; i <= 8; i++) begin
      chk({tag, " valid early"}, 32'(rpt_valid), 0);
      node_in = v.pat[8-i];
      tick();
    end
    node_in = 1'b0;
    chk({tag, " valid at k+N"}, 32'(rpt_valid), 1);
    chk_report(tag, v);
  endtask

  task automatic accept(input string tag, input vec_t v);
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
    chk({tag, " valid after accept"}, 32'(rpt_valid), 0);
    chk({tag, " busy after accept"}, 32'(busy), 0);
    chk_report({tag, " idle hold"}, v);
  endtask

  initial begin
    vecs[0]  = '{8'h00, 0, 0, 1'b1, 8'h00};
    vecs[1]  = '{8'hAA, 4, 7, 1'b0, 8'hAA};
    vecs[2]  = '{8'h10, 1, 2, 1'b1, 8'h10};
    vecs[3]  = '{8'hFF, 8, 0, 1'b1, 8'hFF};
    vecs[4]  = '{8'hF0, 4, 1, 1'b0, 8'hF0};
    vecs[5]  = '{8'h01, 1, 1, 1'b1, 8'h01};
    vecs[6]  = '{8'hFE, 7, 1, 1'b1, 8'hFE};
    vecs[7]  = '{8'hC3, 4, 2, 1'b0, 8'hC3};
    vecs[8]  = '{8'h80, 1, 1, 1'b1, 8'h80};
    vecs[9]  = '{8'h03, 2, 1, 1'b0, 8'h03};
    vecs[10] = '{8'hFC, 6, 1, 1'b0, 8'hFC};

    rst = 1'b1; start = 1'b1; node_in = 1'b1; rpt_ready = 1'b0;
    tick();
    tick();
    chk_idle_zero("T1 reset");
    $display("T1 reset with start held: busy=%0d valid=%0d", busy, rpt_valid);
    rst = 1'b0; start = 1'b0; node_in = 1'b0;
    tick();
    chk("T1 idle after reset", 32'(busy), 0);

    for (int i = 0; i < 11; i++) begin
      fill_window($sformatf("vec%0d", i), vecs[i]);
      accept($sformatf("vec%0d", i), vecs[i]);
      $display("window pat=%02h ones=%0d tog=%0d rare=%0d hist=%02h",
               vecs[i].pat, ones_cnt, tog_cnt, rare_flag, history);
      tick();
    end

    // Back-pressure: report must hold and starts must be ignored.
    fill_window("T5", vecs[1]);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      node_in = 1'b1;
      tick();
      chk("T5 valid held", 32'(rpt_valid), 1);
      chk("T5 busy held", 32'(busy), 1);
      chk_report("T5 hold", vecs[1]);
    end
    start = 1'b1;
    accept("T5", vecs[1]);
    start = 1'b0;
    tick();
    chk("T5 start at accept ignored", 32'(busy), 0);
    $display("T5 back-pressure: valid=%0d busy=%0d ones=%0d", rpt_valid, busy, ones_cnt);

    // Abort mid-window at sample s5.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      node_in = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("T6 abort");
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("T6 no report", 32'(rpt_valid), 0);
    end
    $display("T6 abort at s5: busy=%0d valid=%0d ones=%0d", busy, rpt_valid, ones_cnt);
    fill_window("T6 fresh", vecs[3]);
    accept("T6 fresh", vecs[3]);
    $display("T6 fresh all-ones: ones=%0d tog=%0d rare=%0d hist=%02h",
             ones_cnt, tog_cnt, rare_flag, history);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
